// File: rtl/addsub_sequencer_pkg.sv
// Shared types and constants for the add/subtract sequencer.
// Saturation (ADDSUB_SATURATE_EN) limits are derived from the default datapath width.
package addsub_sequencer_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StDone   = 2'd2
  } state_e;

  localparam int unsigned CntW     = 4;
  localparam int unsigned SumWidth = 4;

  localparam logic [SumWidth-1:0] SatMax = {1'b0, {(SumWidth - 1) {1'b1}}};
  localparam logic [SumWidth-1:0] SatMin = {1'b1, {(SumWidth - 1) {1'b0}}};

endpackage

// File: rtl/addsub_sat_clamp.sv
// Combinational signed-overflow clamp used when ADDSUB_SATURATE_EN is defined.
// The sign of operand A picks the limit: positive A saturates high, negative A low.
module addsub_sat_clamp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             a_msb,
  input  logic             ovf,
  input  logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = sum;
    if (ovf) begin
      res = {a_msb, {(WIDTH - 1) {~a_msb}}};
    end
  end

endmodule

// File: rtl/addsub_sequencer.sv
// Sequencer for an external ripple-carry adder/subtractor: register operands, wait settle
// time, capture result. Define ADDSUB_SATURATE_EN to clamp overflowed sums to signed limits.
module addsub_sequencer
  import addsub_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH         = SumWidth,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_sub,
  output logic [WIDTH-1:0] rca_a,
  output logic [WIDTH-1:0] rca_b,
  output logic             rca_cin,
  input  logic [WIDTH-1:0] rca_sum,
  input  logic             rca_c,
  input  logic             rca_ovf,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_c,
  output logic             res_ovf,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [WIDTH-1:0] sum_capt;

`ifdef ADDSUB_SATURATE_EN
  addsub_sat_clamp #(
    .WIDTH(WIDTH)
  ) u_clamp (
    .a_msb(rca_a[WIDTH-1]),
    .ovf  (rca_ovf),
    .sum  (rca_sum),
    .res  (sum_capt)
  );
`else
  assign sum_capt = rca_sum;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      cmd_ready  <= 1'b1;
      res_valid  <= 1'b0;
      rca_a      <= '0;
      rca_b      <= '0;
      rca_cin    <= 1'b0;
      res_sum    <= '0;
      res_c      <= 1'b0;
      res_ovf    <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      // A capture in the case below overrides this clear when both happen together.
      if (clr_sticky) begin
        ovf_sticky <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            rca_a     <= cmd_a;
            rca_b     <= cmd_b;
            rca_cin   <= cmd_sub;
            cnt_q     <= SettleLoad;
            cmd_ready <= 1'b0;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            res_sum   <= sum_capt;
            res_c     <= rca_c;
            res_ovf   <= rca_ovf;
            res_valid <= 1'b1;
            if (rca_ovf) begin
              ovf_sticky <= 1'b1;
            end
            state_q <= StDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StDone: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench: sequencer paired with a bit-level ripple adder/subtractor model,
// results compared against plain signed/unsigned arithmetic.
module tb_addsub_sequencer;

  localparam int W      = 4;
  localparam int SETTLE = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_a = '0;
  logic [W-1:0] cmd_b = '0;
  logic         cmd_sub = 1'b0;
  logic [W-1:0] rca_a;
  logic [W-1:0] rca_b;
  logic         rca_cin;
  logic [W-1:0] rca_sum;
  logic         rca_c;
  logic         rca_ovf;
  logic         res_valid;
  logic         res_ready = 1'b0;
  logic [W-1:0] res_sum;
  logic         res_c;
  logic         res_ovf;
  logic         ovf_sticky;
  logic         clr_sticky = 1'b0;

  int checks = 0;
  int errors = 0;
  logic sticky_exp = 1'b0;

  always #5 clk = ~clk;

  addsub_sequencer #(
    .WIDTH        (W),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_sub   (cmd_sub),
    .rca_a     (rca_a),
    .rca_b     (rca_b),
    .rca_cin   (rca_cin),
    .rca_sum   (rca_sum),
    .rca_c     (rca_c),
    .rca_ovf   (rca_ovf),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_c     (res_c),
    .res_ovf   (res_ovf),
    .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky)
  );

  // External ripple unit: A + (B ^ {W{Cin}}) + Cin, bit by bit.
  logic [W:0]   rc;
  logic [W-1:0] rs;
  always_comb begin
    rc    = '0;
    rs    = '0;
    rc[0] = rca_cin;
    for (int i = 0; i < W; i++) begin
      rs[i]   = rca_a[i] ^ (rca_b[i] ^ rca_cin) ^ rc[i];
      rc[i+1] = (rca_a[i] & (rca_b[i] ^ rca_cin)) | (rc[i] & (rca_a[i] ^ (rca_b[i] ^ rca_cin)));
    end
  end
  assign rca_sum = rs;
  assign rca_c   = rc[W];
  assign rca_ovf = rc[W] ^ rc[W-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: integer arithmetic on unsigned and signed interpretations.
  function automatic void model(input int a, input int b, input bit sub,
                                output logic [W-1:0] s, output logic c, output logic o);
    int sa, sb, r, u;
    sa = (a > 7) ? a - 16 : a;
    sb = (b > 7) ? b - 16 : b;
    if (sub) begin
      u = a - b;
      r = sa - sb;
      c = (a >= b);
    end else begin
      u = a + b;
      r = sa + sb;
      c = (u > 15);
    end
    o = (r > 7) || (r < -8);
    s = u[W-1:0];
`ifdef ADDSUB_SATURATE_EN
    if (o) s = (sa >= 0) ? 4'd7 : 4'd8;
`endif
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_rca_a"}, rca_a, 0);
    chk({tag, "_rca_b"}, rca_b, 0);
    chk({tag, "_rca_cin"}, rca_cin, 0);
    chk({tag, "_res_sum"}, res_sum, 0);
    chk({tag, "_res_c"}, res_c, 0);
    chk({tag, "_res_ovf"}, res_ovf, 0);
    chk({tag, "_sticky"}, ovf_sticky, 0);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int hold, input logic clr_cap, input string tag);
    logic [W-1:0] es;
    logic ec, eo;
    int lat;
    model(int'(a), int'(b), sub, es, ec, eo);
    res_ready = (hold == 0);
    cmd_a = a;
    cmd_b = b;
    cmd_sub = sub;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_ready_before"}, cmd_ready, 1);
    @(posedge clk);
    #1;
    // Junk on the command port must be ignored while busy.
    cmd_valid = 1'($urandom);
    cmd_a = W'($urandom);
    cmd_b = W'($urandom);
    cmd_sub = 1'($urandom);
    chk({tag, "_rca_a"}, rca_a, a);
    chk({tag, "_rca_b"}, rca_b, b);
    chk({tag, "_rca_cin"}, rca_cin, sub);
    chk({tag, "_busy"}, cmd_ready, 0);
    lat = 0;
    while (!res_valid && lat < 20) begin
      if (clr_cap && lat == SETTLE - 1) clr_sticky = 1'b1;
      @(posedge clk);
      #1;
      clr_sticky = 1'b0;
      lat++;
    end
    if (eo) sticky_exp = 1'b1;
    else if (clr_cap) sticky_exp = 1'b0;
    chk({tag, "_latency"}, lat, SETTLE);
    chk({tag, "_res_sum"}, res_sum, es);
    chk({tag, "_res_c"}, res_c, ec);
    chk({tag, "_res_ovf"}, res_ovf, eo);
    chk({tag, "_sticky"}, ovf_sticky, sticky_exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, res_valid, 1);
      chk({tag, "_hold_sum"}, res_sum, es);
      chk({tag, "_hold_c"}, res_c, ec);
      chk({tag, "_hold_ready"}, cmd_ready, 0);
      chk({tag, "_hold_rca_a"}, rca_a, a);
    end
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    chk({tag, "_valid_drop"}, res_valid, 0);
    chk({tag, "_ready_back"}, cmd_ready, 1);
    chk({tag, "_rca_held"}, rca_a, a);
  endtask

  task automatic clear_alone(input string tag);
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    sticky_exp = 1'b0;
    chk(tag, ovf_sticky, 0);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset("reset");

    run_op(4'd10, 4'd2, 1'b1, 0, 1'b0, "sub");
    run_op(4'd7, 4'd1, 1'b0, 0, 1'b0, "ovf_add");
    clear_alone("clr_after_add");
    run_op(4'd15, 4'd15, 1'b1, 5, 1'b0, "backpressure");
    run_op(4'd8, 4'd1, 1'b1, 0, 1'b1, "sticky_prio");
    clear_alone("clr_after_prio");

    // Reset one cycle into SETTLE: result must never appear.
    cmd_a = 4'd10;
    cmd_b = 4'd2;
    cmd_sub = 1'b1;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sticky_exp = 1'b0;
    check_reset("mid_reset");
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("mid_reset_no_valid", res_valid, 0);
    end
    run_op(4'd10, 4'd2, 1'b1, 1, 1'b0, "after_reset");

    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
             1'($urandom), "rand");
      if ($urandom_range(0, 3) == 0) clear_alone("rand_clr");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/addsub_sequencer.md
Name: addsub_sequencer

Overview:
- Sequential front/back-end for the 4-bit ripple-carry adder/subtractor datapath.
- Accepts an operand command over a valid/ready handshake and drives registered A/B/Cin into the external ripple unit.
- Waits a programmable settle time to cover worst-case ripple delay, then captures Sum/carry/overflow and presents the result over a second valid/ready handshake.
- Also keeps a sticky overflow flag for the surrounding control logic.

Parameters:
- WIDTH, 4, operand/result width in bits; must match the ripple unit.
- SETTLE_CYCLES, 2, clock cycles between driving the ripple unit and sampling it; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  block can accept a command
- cmd_a  input  WIDTH  minuend/augend
- cmd_b  input  WIDTH  subtrahend/addend
- cmd_sub  input  1  1 = subtract, 0 = add
- rca_a  output  WIDTH  to ripple unit A
- rca_b  output  WIDTH  to ripple unit B
- rca_cin  output  1  to ripple unit Cin
- rca_sum  input  WIDTH  from ripple unit Sum
- rca_c  input  1  from ripple unit carry-out
- rca_ovf  input  1  from ripple unit signed overflow
- res_valid  output  1  result present
- res_ready  input  1  consumer accepts result
- res_sum  output  WIDTH  captured (possibly saturated) sum
- res_c  output  1  captured carry-out (subtract: 1 = no borrow)
- res_ovf  output  1  captured signed overflow
- ovf_sticky  output  1  set by any captured overflow
- clr_sticky  input  1  clears ovf_sticky

Behaviour:
- Clock and reset: single clock domain, clk only. rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset values: state = IDLE; cmd_ready = 1; res_valid = 0; rca_a, rca_b, rca_cin, res_sum, res_c, res_ovf, ovf_sticky and the settle counter all 0.
- The ripple unit computes A + (B XOR {WIDTH{Cin}}) + Cin. The block drives rca_b = cmd_b unmodified and rca_cin = cmd_sub.
- FSM:
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready: register cmd_a→rca_a, cmd_b→rca_b, cmd_sub→rca_cin; load counter = SETTLE_CYCLES-1; go to SETTLE.
  - SETTLE: cmd_ready = 0. Decrement the counter each cycle. When counter == 0, capture rca_sum/rca_c/rca_ovf into res_*, set res_valid, go to DONE.
  - DONE: cmd_ready = 0; res_valid = 1. res_* and rca_* are held stable. On res_valid && res_ready: clear res_valid, go to IDLE.
- Latency: command accepted at edge k, res_valid asserts after edge k+SETTLE_CYCLES. Earliest next accept is the cycle after the result handshake. Throughput is one result per SETTLE_CYCLES+2 cycles at full res_ready.
- No command overlap: cmd_valid is ignored outside IDLE, and the cmd_* inputs are don't-care there.
- rca_* hold their last values in IDLE; they are not cleared after a result.
- Sticky flag:
  - ovf_sticky is set in the capture cycle when rca_ovf = 1.
  - clr_sticky clears it.
  - If set and clear occur in the same cycle, set wins.
- Reset mid-operation (SETTLE or DONE): the block returns to the reset values on the next edge. Any in-flight result is discarded and no res_valid pulse occurs.
- res_ready asserted while res_valid = 0 has no effect.

Optional Feature:
- Macro: ADDSUB_SATURATE_EN.
- Defined: when the captured rca_ovf = 1, res_sum is clamped to a signed limit instead of the wrapped value.
  - rca_a[WIDTH-1] = 0 gives the maximum positive value (4'b0111).
  - rca_a[WIDTH-1] = 1 gives the minimum negative value (4'b1000).
  - res_ovf and ovf_sticky still report the overflow.
- Undefined: res_sum is always the wrapped two's-complement rca_sum.

Decomposition:
- Shared package: the FSM state encoding (IDLE = 2'd0, SETTLE = 2'd1, DONE = 2'd2) and the saturation limit constants derived from WIDTH.
- Counter width is a localparam of 4 bits, sized for SETTLE_CYCLES ≤ 15.
- One natural sub-module: addsub_sat_clamp, the combinational overflow clamp used under ADDSUB_SATURATE_EN.
- The bench pairs the sequencer with the existing ripple subtractor; no other sub-modules.

Test Plan:
- Reset: assert rst for 2 cycles → cmd_ready = 1, res_valid = 0, all data outputs 0, ovf_sticky = 0.
- Subtract: cmd_a = 10, cmd_b = 2, cmd_sub = 1, res_ready = 1, SETTLE_CYCLES = 2 → rca_cin = 1; res_valid rises exactly 2 edges after accept; res_sum = 8, res_c = 1, res_ovf = 0.
- Overflow, add path: cmd_a = 7, cmd_b = 1, cmd_sub = 0.
  - Macro undefined → res_sum = 4'b1000, res_ovf = 1, ovf_sticky = 1.
  - ADDSUB_SATURATE_EN defined → res_sum = 4'b0111.
- Backpressure: 15 − 15 with res_ready = 0 for 5 cycles → res_valid stays 1, res_sum = 0 and res_c = 1 stay stable, cmd_ready = 0; when res_ready goes high, res_valid drops on the next edge and cmd_ready returns to 1.
- Sticky priority: clr_sticky asserted in the same cycle as a capture of overflow (−8 − 1) → ovf_sticky = 1; clr_sticky alone on a later cycle → ovf_sticky = 0.
- Reset mid-SETTLE: accept 10 − 2, assert rst one cycle later → no res_valid pulse, outputs return to reset values, and the next command completes normally.
